// File: rtl/sobel_edge_detect_8bit_pkg.sv
// Shared widths and arithmetic helpers for the Sobel edge detector.
// The per-stage widths are sized so that no stage can overflow.
package sobel_pkg;

    localparam int unsigned SUM_W = 10;
    localparam int unsigned MAG_W = 11;
    localparam int unsigned CNT_W = 20;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [SUM_W-1:0] sobel_abs_diff(
        input logic [SUM_W-1:0] a,
        input logic [SUM_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sobel_edge_detect_8bit_sync_delay.sv
// N-stage shift register used to delay video syncs so they match the data pipeline.
// Requires N >= 2.
module sync_delay #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    always_comb begin
        sr_d = {sr_q[N-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[N-1];

endmodule

// File: rtl/sobel_edge_detect_8bit.sv
// Four-stage Sobel |Gx|+|Gy| edge detector with thresholded edge flag,
// sync delay matching, and a per-frame edge-pixel counter.
module sobel_edge_detect_8bit
    import sobel_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP      = 11'd1280,
    parameter logic [10:0] IMG_VDISP      = 11'd720,
    parameter logic [7:0]  THRESH_DEFAULT = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        matrix_frame_vsync,
    input  logic        matrix_frame_href,
    input  logic [7:0]  matrix_p11,
    input  logic [7:0]  matrix_p12,
    input  logic [7:0]  matrix_p13,
    input  logic [7:0]  matrix_p21,
    input  logic [7:0]  matrix_p22,
    input  logic [7:0]  matrix_p23,
    input  logic [7:0]  matrix_p31,
    input  logic [7:0]  matrix_p32,
    input  logic [7:0]  matrix_p33,
    input  logic [7:0]  sobel_threshold,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic [7:0]  post_img_edge,
    output logic        post_img_bit,
    output logic [19:0] frame_edge_count,
    output logic        frame_count_valid
);

    // A full frame of edge pixels must fit in the counter.
    if (32'(IMG_HDISP) * 32'(IMG_VDISP) > 32'(CNT_MAX)) begin : g_cnt_width_check
        $error("edge counter too narrow for frame size");
    end

    logic [SUM_W-1:0] xp_q, xp_d, xn_q, xn_d, yp_q, yp_d, yn_q, yn_d;
    logic [SUM_W-1:0] gx_q, gx_d, gy_q, gy_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic [7:0]       edge_q, edge_d;
    logic             bit_q, bit_d;
    logic [7:0]       thr_q, thr_d;
    logic             vs_prev_q, vs_prev_d;
    logic             post_vs_prev_q, post_vs_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] fec_q, fec_d;
    logic             qual, post_rise;

    always_comb begin
        xp_d = {2'b0, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b0, matrix_p33};
        xn_d = {2'b0, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b0, matrix_p31};
        yp_d = {2'b0, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b0, matrix_p13};
        yn_d = {2'b0, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b0, matrix_p33};
        gx_d = sobel_abs_diff(xp_q, xn_q);
        gy_d = sobel_abs_diff(yp_q, yn_q);
        mag_d = {1'b0, gx_q} + {1'b0, gy_q};
        edge_d = (mag_q > MAG_W'(255)) ? 8'hFF : mag_q[7:0];
        bit_d  = (mag_q > {3'b0, thr_q});
    end

    // Threshold is only taken on the input vsync rise so a frame uses one value throughout.
    always_comb begin
        vs_prev_d = matrix_frame_vsync;
        thr_d     = thr_q;
        if (matrix_frame_vsync && !vs_prev_q) begin
            thr_d = sobel_threshold;
        end
    end

    sync_delay #(.N(4)) u_vsync_delay (
        .clk (clk),
        .rst (rst),
        .d   (matrix_frame_vsync),
        .q   (post_frame_vsync)
    );

    sync_delay #(.N(4)) u_href_delay (
        .clk (clk),
        .rst (rst),
        .d   (matrix_frame_href),
        .q   (post_frame_href)
    );

    assign post_img_edge = post_frame_href ? edge_q : '0;
    assign post_img_bit  = post_frame_href & bit_q;

    // A pixel coinciding with the vsync rise lands in both the closing report and the new count.
    always_comb begin
        qual           = post_frame_href & post_img_bit;
        post_rise      = post_frame_vsync & ~post_vs_prev_q;
        post_vs_prev_d = post_frame_vsync;
        cnt_inc        = (qual && (cnt_q != CNT_MAX)) ? (cnt_q + 1'b1) : cnt_q;
        cnt_d          = cnt_inc;
        fec_d          = fec_q;
        if (post_rise) begin
            cnt_d = CNT_W'(qual);
            fec_d = cnt_inc;
        end
    end

    assign frame_edge_count  = fec_q;
    assign frame_count_valid = post_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xp_q           <= '0;
            xn_q           <= '0;
            yp_q           <= '0;
            yn_q           <= '0;
            gx_q           <= '0;
            gy_q           <= '0;
            mag_q          <= '0;
            edge_q         <= '0;
            bit_q          <= 1'b0;
            thr_q          <= THRESH_DEFAULT;
            vs_prev_q      <= 1'b0;
            post_vs_prev_q <= 1'b0;
            cnt_q          <= '0;
            fec_q          <= '0;
        end else begin
            xp_q           <= xp_d;
            xn_q           <= xn_d;
            yp_q           <= yp_d;
            yn_q           <= yn_d;
            gx_q           <= gx_d;
            gy_q           <= gy_d;
            mag_q          <= mag_d;
            edge_q         <= edge_d;
            bit_q          <= bit_d;
            thr_q          <= thr_d;
            vs_prev_q      <= vs_prev_d;
            post_vs_prev_q <= post_vs_prev_d;
            cnt_q          <= cnt_d;
            fec_q          <= fec_d;
        end
    end

endmodule

// File: tb/tb_sobel_edge_detect_8bit.sv
// Directed bench for sobel_edge_detect_8bit: hand-computed windows, sync alignment,
// threshold timing, frame edge counting and asynchronous reset.
module tb_sobel_edge_detect_8bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  p11 = '0, p12 = '0, p13 = '0;
    logic [7:0]  p21 = '0, p22 = '0, p23 = '0;
    logic [7:0]  p31 = '0, p32 = '0, p33 = '0;
    logic [7:0]  thr = 8'd64;
    logic        post_vsync, post_href, post_bit, cnt_valid;
    logic [7:0]  post_edge;
    logic [19:0] edge_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Windows packed p11,p12,p13,p21,p22,p23,p31,p32,p33 from the MSB down.
    localparam logic [71:0] FLAT = {9{8'd128}};
    localparam logic [71:0] STEP = {3{8'd0, 8'd0, 8'd255}};              // Gx=1020, Gy=0
    localparam logic [71:0] M64  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd32, 8'd0, 8'd0, 8'd0};
    // Magnitude is always even, so 66 is the first value above 64.
    localparam logic [71:0] M66  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd33, 8'd0, 8'd0, 8'd0};
    localparam logic [71:0] D100 = {8'd100, 64'd0};                       // Gx=-100, Gy=100
    localparam logic [71:0] C40  = {64'd0, 8'd40};                        // Gx=40, Gy=-40

    always #5 clk = ~clk;

    sobel_edge_detect_8bit #(
        .IMG_HDISP      (11'd1280),
        .IMG_VDISP      (11'd720),
        .THRESH_DEFAULT (8'd64)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .matrix_frame_vsync (vsync),
        .matrix_frame_href  (href),
        .matrix_p11         (p11),
        .matrix_p12         (p12),
        .matrix_p13         (p13),
        .matrix_p21         (p21),
        .matrix_p22         (p22),
        .matrix_p23         (p23),
        .matrix_p31         (p31),
        .matrix_p32         (p32),
        .matrix_p33         (p33),
        .sobel_threshold    (thr),
        .post_frame_vsync   (post_vsync),
        .post_frame_href    (post_href),
        .post_img_edge      (post_edge),
        .post_img_bit       (post_bit),
        .frame_edge_count   (edge_count),
        .frame_count_valid  (cnt_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_win(input logic [71:0] w);
        {p11, p12, p13, p21, p22, p23, p31, p32, p33} = w;
    endtask

    task automatic run_win(input string tag, input logic [71:0] w,
                           input logic [7:0] exp_edge, input logic exp_bit);
        set_win(w);
        href = 1'b1;
        repeat (4) tick();
        check({tag, "_edge"}, 32'(post_edge), 32'(exp_edge));
        check({tag, "_bit"}, 32'(post_bit), 32'(exp_bit));
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        repeat (6) tick();
    endtask

    task automatic pixels(input int n, input logic [71:0] w, input logic h);
        set_win(w);
        href = h;
        repeat (n) tick();
        href = 1'b0;
    endtask

    task automatic frame_rise(input string tag, input logic [19:0] exp_cnt,
                              input logic chk_cnt, input logic coincident);
        set_win(STEP);
        vsync = 1'b1;
        href  = coincident;
        tick();
        href = 1'b0;
        tick();
        vsync = 1'b0;
        tick();
        check({tag, "_valid_early"}, 32'(cnt_valid), 32'd0);
        tick();
        check({tag, "_valid_pulse"}, 32'(cnt_valid), 32'd1);
        tick();
        check({tag, "_valid_width"}, 32'(cnt_valid), 32'd0);
        if (chk_cnt) check({tag, "_count"}, 32'(edge_count), 32'(exp_cnt));
        repeat (4) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vsync"}, 32'(post_vsync), 32'd0);
        check({tag, "_href"},  32'(post_href),  32'd0);
        check({tag, "_edge"},  32'(post_edge),  32'd0);
        check({tag, "_bit"},   32'(post_bit),   32'd0);
        check({tag, "_count"}, 32'(edge_count), 32'd0);
        check({tag, "_valid"}, 32'(cnt_valid),  32'd0);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Arithmetic with default threshold 64
        run_win("flat",  FLAT, 8'd0,   1'b0);
        check("flat_href", 32'(post_href), 32'd1);
        run_win("vstep", STEP, 8'd255, 1'b1);
        run_win("m64",   M64,  8'd64,  1'b0);
        run_win("m66",   M66,  8'd66,  1'b1);
        run_win("diag",  D100, 8'd200, 1'b1);
        run_win("corner", C40, 8'd80,  1'b1);

        // Mid-frame threshold change is ignored until the next vsync rise
        thr = 8'd200;
        run_win("thr_hold", M66, 8'd66, 1'b1);
        vs_pulse();
        run_win("thr200_m66", M66, 8'd66, 1'b0);
        run_win("thr200_eq", D100, 8'd200, 1'b0);
        run_win("thr200_step", STEP, 8'd255, 1'b1);
        thr = 8'd64;
        vs_pulse();

        // Sync alignment: 10-clk href pulse with a ramp window (Gx=80)
        href = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 24; i++) begin
            logic exp_h;
            exp_h = (i >= 6) && (i < 16);
            check("align_href", 32'(post_href), 32'(exp_h));
            check("align_edge", 32'(post_edge), exp_h ? 32'd80 : 32'd0);
            check("align_bit",  32'(post_bit),  32'(exp_h));
            set_win({3{8'(i), 8'(i + 10), 8'(i + 20)}});
            href = (i >= 2) && (i < 12);
            tick();
        end
        href = 1'b0;
        repeat (6) tick();

        // Frame counting
        frame_rise("f1", 20'd0, 1'b0, 1'b0);
        pixels(20, STEP, 1'b1);
        pixels(5,  FLAT, 1'b1);
        pixels(6,  STEP, 1'b0);
        pixels(17, M66,  1'b1);
        repeat (6) tick();
        frame_rise("f2", 20'd37, 1'b1, 1'b0);
        repeat (6) tick();
        frame_rise("f3", 20'd1, 1'b1, 1'b1);
        repeat (6) tick();
        frame_rise("f4", 20'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-line with threshold previously raised to 200
        thr = 8'd200;
        vs_pulse();
        run_win("pre_rst_m66", M66, 8'd66, 1'b0);
        set_win(STEP);
        href = 1'b1;
        repeat (5) tick();
        check("pre_rst_edge", 32'(post_edge), 32'd255);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick();
        href = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        set_win(M66);
        href = 1'b1;
        repeat (3) tick();
        set_win(STEP);
        tick();
        check("post_rst_edge", 32'(post_edge), 32'd66);
        check("post_rst_thr_default", 32'(post_bit), 32'd1);
        tick();
        href = 1'b0;
        repeat (6) tick();
        frame_rise("after_rst", 20'd5, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
